hilo_ctrl: RTL and testbench

Sequencing controller between decode/execute and the iterative signed multiplier (`mult`). It accepts HI/LO-class operations (MULT, MFHI, MFLO, MTHI, MTLO) and owns the architectural HI/LO registers. It issues the one-cycle multiplier start, waits for the end pulse and commits the product. It stalls dependent operations while the multiplier is busy and runs a watchdog on the multiplier.

---
 rtl/mips_hilo_pkg.sv | 27 ++
 rtl/hilo_watchdog.sv | 35 +++
 rtl/hilo_ctrl.sv | 149 ++++++++++++++
 tb/tb_hilo_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hilo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_hilo_pkg : op codes, FSM encoding and defaults for hilo_ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_hilo_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_MFHI = 3'd2;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_MADD = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
`ifdef HILO_MADD_EN
  localparam logic [1:0] ST_ACC   = 2'd3;
`endif

  localparam int DEFAULT_TIMEOUT = 40;

endpackage
`default_nettype wire

// File: rtl/hilo_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_watchdog : cycle counter with clear/enable and terminal count   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hilo_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // tc marks the TIMEOUT-th enabled cycle; the counter saturates there
  assign tc = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_ctrl : HI/LO owner and sequencer for the iterative multiplier   |
// | Optional MADD (op 6) enabled by macro HILO_MADD_EN.    Rev 1.0       |
// +----------------------------------------------------------------------+
module hilo_ctrl
  import mips_hilo_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int OPW     = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  input  logic [OPW-1:0] op_code,
  input  logic [31:0]    rs_val,
  input  logic [31:0]    rt_val,
  output logic           op_ready,
  output logic           stall,
  output logic [31:0]    rd_val,
  output logic           rd_valid,
  output logic           mult_start,
  output logic [31:0]    mult_a,
  output logic [31:0]    mult_b,
  output logic           mult_clr,
  input  logic           mult_end,
  input  logic [31:0]    mult_hi,
  input  logic [31:0]    mult_lo,
  output logic [31:0]    hi_q,
  output logic [31:0]    lo_q,
  output logic           busy,
  output logic           err,
  output logic           ill_op
);

  logic [1:0] r_state;
  logic       w_accept;
  logic       w_tc;
  logic       w_abort;

`ifdef HILO_MADD_EN
  logic        r_madd;
  logic [63:0] r_prod;
`endif

  assign op_ready   = (r_state == ST_IDLE);
  assign stall      = op_valid & ~op_ready;
  assign busy       = (r_state != ST_IDLE);
  assign mult_start = (r_state == ST_START);
  assign w_accept   = op_valid & op_ready;

  // mult_end wins over a timeout landing on the same edge
  assign w_abort  = (r_state == ST_WAIT) & ~mult_end & w_tc;
  assign mult_clr = ~rst | w_abort;

  hilo_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (r_state == ST_START),
    .en  (r_state == ST_WAIT),
    .tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      rd_val   <= '0;
      rd_valid <= 1'b0;
      mult_a   <= '0;
      mult_b   <= '0;
      err      <= 1'b0;
      ill_op   <= 1'b0;
`ifdef HILO_MADD_EN
      r_madd   <= 1'b0;
      r_prod   <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      ill_op   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_code)
              OP_NOP: ;
              OP_MULT: begin
                mult_a  <= rs_val;
                mult_b  <= rt_val;
                r_state <= ST_START;
`ifdef HILO_MADD_EN
                r_madd  <= 1'b0;
`endif
              end
`ifdef HILO_MADD_EN
              OP_MADD: begin
                mult_a  <= rs_val;
                mult_b  <= rt_val;
                r_state <= ST_START;
                r_madd  <= 1'b1;
              end
`endif
              OP_MFHI: begin
                rd_val   <= hi_q;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_val   <= lo_q;
                rd_valid <= 1'b1;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ill_op <= 1'b1;
            endcase
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (mult_end) begin
`ifdef HILO_MADD_EN
            if (r_madd) begin
              r_prod  <= {mult_hi, mult_lo};
              r_state <= ST_ACC;
            end else begin
              {hi_q, lo_q} <= {mult_hi, mult_lo};
              r_state      <= ST_IDLE;
            end
`else
            {hi_q, lo_q} <= {mult_hi, mult_lo};
            r_state      <= ST_IDLE;
`endif
          end else if (w_tc) begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
`ifdef HILO_MADD_EN
        ST_ACC: begin
          {hi_q, lo_q} <= {hi_q, lo_q} + r_prod;
          r_state      <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_ctrl : directed self-checking bench for hilo_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hilo_ctrl;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        op_ready, stall, rd_valid, mult_start, mult_clr;
  logic [31:0] rd_val, mult_a, mult_b, hi_q, lo_q;
  logic        busy, err, ill_op;
  logic        mult_end;
  logic [31:0] mult_hi = '0;
  logic [31:0] mult_lo = '0;

  logic        model_en  = 1'b1;
  logic        model_end = 1'b0;
  logic        man_end   = 1'b0;
  logic [6:0]  mcnt      = '0;

  int total = 0;
  int bad   = 0;

  assign mult_end = model_end | man_end;

  always #5 clk = ~clk;

  hilo_ctrl #(.TIMEOUT(TIMEOUT), .OPW(3)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .stall(stall),
    .rd_val(rd_val), .rd_valid(rd_valid), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .mult_clr(mult_clr),
    .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi_q(hi_q), .lo_q(lo_q), .busy(busy), .err(err), .ill_op(ill_op)
  );

  // Multiplier stand-in: end pulse 33 cycles after the start cycle
  always @(posedge clk) begin
    logic signed [63:0] p;
    model_end <= 1'b0;
    if (mult_clr) begin
      mcnt <= '0;
    end else if (mult_start && model_en) begin
      p = $signed(mult_a) * $signed(mult_b);
      {mult_hi, mult_lo} <= p;
      mcnt <= 7'd32;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1'b1;
      if (mcnt == 7'd1) model_end <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE; returns at #1 after its acceptance edge
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = c;
    rs_val   = a;
    rt_val   = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!mult_end && n < 80) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, mult_end}, 64'd1);
  endtask

  initial begin
    int first_clr;
    int n_clr;
    int n;
    logic stall_ok;

    #12;
    chk("rst_hi", hi_q, 0);
    chk("rst_lo", lo_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_clr", mult_clr, 1);
    chk("rst_ready", op_ready, 1);
    chk("rst_outs", {rd_valid, mult_start, ill_op, mult_a, mult_b}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("clr_after_rst", mult_clr, 0);

    // MTHI/MTLO then MFHI/MFLO
    do_op(3'd4, 32'h12345678, 0);
    chk("mthi", hi_q, 32'h12345678);
    do_op(3'd5, 32'h9ABCDEF0, 0);
    chk("mtlo", lo_q, 32'h9ABCDEF0);
    op_valid = 1'b1; op_code = 3'd2;
    tick();
    chk("mfhi_valid", rd_valid, 1);
    chk("mfhi_val", rd_val, 32'h12345678);
    op_code = 3'd3;
    tick();
    op_valid = 1'b0;
    chk("mflo_valid", rd_valid, 1);
    chk("mflo_val", rd_val, 32'h9ABCDEF0);
    tick();
    chk("rd_valid_pulse", rd_valid, 0);

    // MULT 7 x -3
    do_op(3'd1, 32'd7, 32'hFFFFFFFD);
    chk("start_hi", mult_start, 1);
    chk("mult_a", mult_a, 32'd7);
    chk("mult_b", mult_b, 32'hFFFFFFFD);
    chk("busy_start", busy, 1);
    tick();
    chk("start_pulse", mult_start, 0);
    chk("mult_a_hold", mult_a, 32'd7);
    wait_end("mult1_end_seen");
    chk("busy_at_end", busy, 1);
    tick();
    chk("busy_fell", busy, 0);
    chk("mult1_hi", hi_q, 32'hFFFFFFFF);
    chk("mult1_lo", lo_q, 32'hFFFFFFEB);

    // MULT min x min with MFLO held behind it
    do_op(3'd1, 32'h80000000, 32'h80000000);
    op_valid = 1'b1; op_code = 3'd3;
    #1;
    stall_ok = stall & ~op_ready;
    n = 0;
    while (!mult_end && n < 80) begin
      tick();
      n++;
      if (!stall) stall_ok = 1'b0;
    end
    chk("stall_held", {63'd0, stall_ok & mult_end}, 64'd1);
    tick();
    chk("stall_released", stall, 0);
    chk("mult2_hi", hi_q, 32'h40000000);
    tick();
    op_valid = 1'b0;
    chk("mflo2_valid", rd_valid, 1);
    chk("mflo2_val", rd_val, 32'h00000000);

    // Watchdog timeout
    model_en = 1'b0;
    do_op(3'd1, 32'd2, 32'd2);
    first_clr = 0;
    n_clr = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (mult_clr) begin
        if (first_clr == 0) first_clr = i;
        n_clr++;
      end
    end
    chk("clr_cycle", first_clr, TIMEOUT);
    chk("clr_count", n_clr, 1);
    chk("err_set", err, 1);
    chk("to_hi", hi_q, 32'h40000000);
    chk("to_lo", lo_q, 32'h00000000);
    chk("to_idle", op_ready, 1);
    do_op(3'd5, 32'hCAFEF00D, 0);
    chk("mtlo_after_to", lo_q, 32'hCAFEF00D);
    chk("err_sticky", err, 1);

    // Reset in the middle of WAIT
    model_en = 1'b1;
    do_op(3'd1, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_hilo", {hi_q, lo_q}, 0);
    chk("ar_err", err, 0);
    chk("ar_clr", mult_clr, 1);
    chk("ar_outs", {mult_start, rd_valid, ill_op, mult_a, mult_b}, 0);
    tick();
    rst = 1'b1;
    tick();
    man_end = 1'b1;
    tick();
    man_end = 1'b0;
    tick();
    chk("late_end_busy", busy, 0);
    chk("late_end_hilo", {hi_q, lo_q}, 0);

`ifdef HILO_MADD_EN
    do_op(3'd4, 32'h00000000, 0);
    do_op(3'd5, 32'hFFFFFFFF, 0);
    do_op(3'd6, 32'd1, 32'd1);
    chk("madd_start", mult_start, 1);
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk("madd_done", busy, 0);
    chk("madd_hi", hi_q, 32'h00000001);
    chk("madd_lo", lo_q, 32'h00000000);
`else
    do_op(3'd4, 32'h00000000, 0);
    do_op(3'd5, 32'hFFFFFFFF, 0);
    do_op(3'd6, 32'd1, 32'd1);
    chk("op6_ill", ill_op, 1);
    chk("op6_idle", {busy, mult_start}, 0);
    tick();
    chk("op6_pulse", ill_op, 0);
    chk("op6_hilo", {hi_q, lo_q}, 64'h00000000_FFFFFFFF);
`endif
    do_op(3'd7, 32'h55555555, 0);
    chk("op7_ill", ill_op, 1);
    chk("op7_hilo", {hi_q, lo_q}, 64'h00000000_FFFFFFFF);
    do_op(3'd0, 32'h55555555, 0);
    chk("nop_quiet", {ill_op, rd_valid, busy}, 0);
    chk("nop_hilo", {hi_q, lo_q}, 64'h00000000_FFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
